data_mem_bytelane: RTL

// Parametrised successor data memory for the single-cycle MIPS datapath; sits behind the ALU result bus in the MEM stage.

---
 rtl/data_mem_bytelane_if.sv | 25 ++
 rtl/data_mem_bytelane.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/data_mem_bytelane_if.sv
// Request/response bundle between the MEM stage and the byte-lane data memory.
interface data_mem_bytelane_if #(
    parameter int unsigned ADDR_WIDTH = 9
) ();
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           write_data;
    logic                  MemWrite;
    logic                  MemRead;
    logic [1:0]            size;
    logic                  unsigned_ld;
    logic [31:0]           read_data;
    logic                  read_valid;
    logic                  misaligned;
    logic                  ready;

    modport master (
        output address, write_data, MemWrite, MemRead, size, unsigned_ld,
        input  read_data, read_valid, misaligned, ready
    );

    modport slave (
        input  address, write_data, MemWrite, MemRead, size, unsigned_ld,
        output read_data, read_valid, misaligned, ready
    );
endinterface

// File: rtl/data_mem_bytelane.sv
// Byte-addressed little-endian data memory with byte-lane stores, sign/zero-extending
// registered loads, misalignment flagging and a post-reset zero-fill sweep.
module data_mem_bytelane #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input logic                clock,
    input logic                reset_n,
    data_mem_bytelane_if.slave bus
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            clear_we;

    logic [31:0]     mem_q [DEPTH];
    logic [IdxW-1:0] idx;
    logic [1:0]      lane;
    logic            bad;
    logic [31:0]     rd_word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_val;
    logic [3:0]      be;
    logic [31:0]     wword;
    logic [IdxW-1:0] wr_idx;

    logic [31:0]     read_data_q, read_data_d;
    logic            read_valid_q, read_valid_d;
    logic            misaligned_q, misaligned_d;

    assign idx  = bus.address[ADDR_WIDTH-1:2];
    assign lane = bus.address[1:0];

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT_CLEAR ? StClear : StRun;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IdxW'(DEPTH - 1)) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs; ready is registered so it rises on the edge that clears the last word
    always_comb begin
        clear_we = (state_q == StClear);
        ready_d  = (state_d == StRun);
    end

    always_comb begin
        case (bus.size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = bus.address[0];
            2'b10:   bad = |bus.address[1:0];
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        rd_word  = mem_q[idx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{lane[1], 4'b0000} +: 16];
        case (bus.size)
            2'b00:   load_val = {{24{~bus.unsigned_ld & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~bus.unsigned_ld & half_sel[15]}}, half_sel};
            default: load_val = rd_word;
        endcase
    end

    // Store data is replicated across lanes so the enables alone pick the target bytes
    always_comb begin
        be     = 4'b0000;
        wword  = 32'h0;
        wr_idx = idx;
        if (clear_we) begin
            be     = 4'b1111;
            wr_idx = cnt_q;
        end else if (ready_q && bus.MemWrite && !bad) begin
            case (bus.size)
                2'b00: begin
                    be    = 4'b0001 << lane;
                    wword = {4{bus.write_data[7:0]}};
                end
                2'b01: begin
                    be    = lane[1] ? 4'b1100 : 4'b0011;
                    wword = {2{bus.write_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wword = bus.write_data;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[wr_idx][8*b +: 8] <= wword[8*b +: 8];
        end
    end

    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        misaligned_d = 1'b0;
        if (ready_q) begin
            misaligned_d = (bus.MemRead | bus.MemWrite) & bad;
            read_valid_d = bus.MemRead;
            if (bus.MemRead) read_data_d = bad ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data_q  <= 32'h0;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign bus.misaligned = misaligned_q;
    assign bus.ready      = ready_q;
endmodule
